// File: rtl/onchip_mem_stream_loader_if.sv
// rtl/onchip_mem_stream_loader_if.sv - byte stream input and RAM write-port bundle
interface onchip_mem_stream_loader_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_chipselect;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_clken;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_chipselect, mem_write, mem_address,
    output mem_byteenable, mem_writedata, mem_clken
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_chipselect, mem_write, mem_address,
    input  mem_byteenable, mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_mem_stream_loader.sv
// rtl/onchip_mem_stream_loader.sv - packs a byte stream little-endian into RAM words
// Outputs are registered copies of values computed from the next state and datapath.
module onchip_mem_stream_loader #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 10240,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [CNT_W-1:0]          byte_count,
  onchip_mem_stream_loader_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [ADDR_W:0]           words_written
);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  state_t            state, next_state;
  logic [ADDR_W:0]   cur_addr;
  logic [CNT_W-1:0]  bytes_left;
  logic [1:0]        lane;
  logic [31:0]       data, data_nxt;
  logic [3:0]        be, be_nxt;
  logic              hs, going_write, addr_ok, strobe;

  logic              in_ready_d, busy_d, done_d, overflow_d;
  logic [ADDR_W:0]   words_written_d;
  logic [ADDR_W-1:0] mem_address_d;
  logic [3:0]        mem_byteenable_d;
  logic [31:0]       mem_writedata_d;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    hs = bus.in_valid & bus.in_ready;
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (byte_count == '0) ? DONE : COLLECT;
      COLLECT: if (hs && (lane == 2'd3 || bytes_left == CNT_W'(1))) next_state = WRITE;
      WRITE:   next_state = (bytes_left == '0) ? DONE : COLLECT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Word as it will look once the byte on the bus lands in its lane.
  always_comb begin
    data_nxt = data;
    be_nxt   = be;
    data_nxt[{lane, 3'b000} +: 8] = bus.in_data;
    be_nxt[lane] = 1'b1;
  end

  always_comb begin
    going_write      = (state == COLLECT) && (next_state == WRITE);
    addr_ok          = cur_addr < DEPTH_LIM;
    strobe           = going_write && addr_ok;
    in_ready_d       = next_state == COLLECT;
    busy_d           = next_state != IDLE;
    done_d           = next_state == DONE;
    mem_address_d    = strobe ? cur_addr[ADDR_W-1:0] : '0;
    mem_byteenable_d = strobe ? be_nxt : '0;
    mem_writedata_d  = strobe ? data_nxt : '0;
    overflow_d       = overflow;
    words_written_d  = words_written;
    if (state == IDLE && start) begin
      overflow_d      = 1'b0;
      words_written_d = '0;
    end else begin
      if (going_write && !addr_ok) overflow_d = 1'b1;
      if (strobe) words_written_d = words_written + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.in_ready       <= 1'b0;
      bus.mem_chipselect <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_byteenable <= '0;
      bus.mem_writedata  <= '0;
      bus.mem_clken      <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      overflow           <= 1'b0;
      words_written      <= '0;
    end else begin
      bus.in_ready       <= in_ready_d;
      bus.mem_chipselect <= strobe;
      bus.mem_write      <= strobe;
      bus.mem_address    <= mem_address_d;
      bus.mem_byteenable <= mem_byteenable_d;
      bus.mem_writedata  <= mem_writedata_d;
      bus.mem_clken      <= 1'b1;
      busy               <= busy_d;
      done               <= done_d;
      overflow           <= overflow_d;
      words_written      <= words_written_d;
    end
  end

  // cur_addr carries one extra bit so running past the top of RAM never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr   <= '0;
      bytes_left <= '0;
      lane       <= '0;
      data       <= '0;
      be         <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cur_addr   <= {1'b0, base_addr};
          bytes_left <= byte_count;
          lane       <= '0;
          data       <= '0;
          be         <= '0;
        end
        COLLECT: if (hs) begin
          data       <= data_nxt;
          be         <= be_nxt;
          lane       <= lane + 2'd1;
          bytes_left <= bytes_left - CNT_W'(1);
        end
        WRITE: begin
          cur_addr <= cur_addr + (ADDR_W+1)'(1);
          lane     <= '0;
          data     <= '0;
          be       <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// tb/tb_onchip_mem_stream_loader.sv - directed self-checking bench for the stream loader
// A word-level model predicts every RAM write; a negedge monitor checks them.
module tb_onchip_mem_stream_loader;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 10240;
  localparam int CNT_W  = 16;

  typedef struct {
    int          addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  byte_count = '0;
  logic              busy, done, overflow;
  logic [ADDR_W:0]   words_written;

  onchip_mem_stream_loader_if #(.ADDR_W(ADDR_W)) bus();

  onchip_mem_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .byte_count(byte_count), .bus(bus), .busy(busy), .done(done),
    .overflow(overflow), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic [7:0] stream [64];
  wr_t  exp_q [$];
  wr_t  wr_log [$];
  int   wr_cyc [$];
  int   exp_ww;
  int   exp_ovf;
  int   done_cnt = 0;
  int   done_cyc = 0;
  wr_t  mon_o, mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected writes from byte stream, base and count alone.
  task automatic model_load(input int base, input int n);
    int nw;
    nw = (n + 3) / 4;
    exp_ww = 0;
    exp_ovf = 0;
    for (int w = 0; w < nw; w++) begin
      wr_t e;
      e.addr = base + w;
      e.data = '0;
      e.be = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) begin
          e.data = e.data | (32'(stream[4 * w + k]) << (8 * k));
          e.be[k] = 1'b1;
        end
      if (e.addr < DEPTH) begin
        exp_q.push_back(e);
        exp_ww++;
      end else exp_ovf = 1;
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_write === 1'b1) begin
      mon_o.addr = int'(bus.mem_address);
      mon_o.data = bus.mem_writedata;
      mon_o.be   = bus.mem_byteenable;
      wr_log.push_back(mon_o);
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h, want no write (cycle %0d)",
                 bus.mem_address, bus.mem_writedata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_address), 32'(mon_e.addr));
        chk("wr_data", bus.mem_writedata, mon_e.data);
        chk("wr_be", 32'(bus.mem_byteenable), 32'(mon_e.be));
      end
    end else begin
      chk("idle_be_zero", 32'(bus.mem_byteenable), 32'd0);
      chk("idle_wd_zero", bus.mem_writedata, 32'd0);
    end
    chk("cs_eq_write", 32'(bus.mem_chipselect), 32'(bus.mem_write));
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic do_start(input int b, input int n);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = ADDR_W'(b);
    byte_count = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps, input bit inject);
    int idx;
    int g;
    bit hs;
    bit injected;
    idx = 0;
    g = 0;
    injected = 0;
    while (idx < n && g < 400) begin
      bus.in_valid = gaps ? (((g * 7 + 3) % 5) >= 2) : 1'b1;
      bus.in_data = stream[idx];
      if (inject && !injected && idx == 5) begin
        start = 1'b1;
        base_addr = ADDR_W'(5);
        byte_count = CNT_W'(3);
        injected = 1;
      end else start = 1'b0;
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      g++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    chk("bytes_accepted", 32'(idx), 32'(n));
  endtask

  task automatic run_transfer(input int base, input int n, input bit gaps, input bit inject);
    int g;
    g = 0;
    model_load(base, n);
    wr_log.delete();
    wr_cyc.delete();
    done_cnt = 0;
    do_start(base, n);
    chk("in_ready_after_start", 32'(bus.in_ready), 32'd1);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("overflow_cleared", 32'(overflow), 32'd0);
    feed(n, gaps, inject);
    while (done_cnt == 0 && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    chk("words_written", 32'(words_written), 32'(exp_ww));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("busy_end", 32'(busy), 32'd0);
    chk("done_low", 32'(done), 32'd0);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_cs"}, 32'(bus.mem_chipselect), 32'd0);
    chk({tag, "_write"}, 32'(bus.mem_write), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_address), 32'd0);
    chk({tag, "_be"}, 32'(bus.mem_byteenable), 32'd0);
    chk({tag, "_wd"}, bus.mem_writedata, 32'd0);
    chk({tag, "_clken"}, 32'(bus.mem_clken), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_ww"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("clken_on", 32'(bus.mem_clken), 32'd1);

    for (int i = 0; i < 8; i++) stream[i] = 8'(i + 1);
    run_transfer(16'h0010, 8, 1'b0, 1'b0);
    chk("t1_nwrites", 32'(wr_log.size()), 32'd2);
    chk("t1_w0_addr", 32'(wr_log[0].addr), 32'h0010);
    chk("t1_w0_data", wr_log[0].data, 32'h04030201);
    chk("t1_w0_be", 32'(wr_log[0].be), 32'hF);
    chk("t1_w1_addr", 32'(wr_log[1].addr), 32'h0011);
    chk("t1_w1_data", wr_log[1].data, 32'h08070605);
    chk("t1_w1_be", 32'(wr_log[1].be), 32'hF);
    chk("t1_strobe_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
    chk("t1_done_after_write", 32'(done_cyc), 32'(wr_cyc[1] + 1));
    chk("t1_ww", 32'(words_written), 32'd2);

    for (int i = 0; i < 6; i++) stream[i] = 8'(8'hAA + 17 * i);
    run_transfer(16'h0100, 6, 1'b0, 1'b0);
    chk("t2_w1_addr", 32'(wr_log[1].addr), 32'h0101);
    chk("t2_w1_data", wr_log[1].data, 32'h0000FFEE);
    chk("t2_w1_be", 32'(wr_log[1].be), 32'h3);

    for (int i = 0; i < 12; i++) stream[i] = 8'(8'h40 + 3 * i);
    run_transfer(10239, 12, 1'b0, 1'b0);
    chk("t3_nwrites", 32'(wr_log.size()), 32'd1);
    chk("t3_addr", 32'(wr_log[0].addr), 32'd10239);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_ww", 32'(words_written), 32'd1);

    chk("t4_busy_before", 32'(busy), 32'd0);
    done_cnt = 0;
    do_start(16'h0050, 0);
    chk("t4_done_next", 32'(done), 32'd1);
    chk("t4_busy_next", 32'(busy), 32'd1);
    chk("t4_overflow_cleared", 32'(overflow), 32'd0);
    chk("t4_ww_cleared", 32'(words_written), 32'd0);
    @(posedge clk); #1;
    chk("t4_done_once", 32'(done), 32'd0);
    chk("t4_busy_once", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) stream[i] = 8'(8'h11 + i);
    run_transfer(16'h0300, 7, 1'b1, 1'b1);
    chk("t5_w0_data", wr_log[0].data, 32'h14131211);
    chk("t5_w1_addr", 32'(wr_log[1].addr), 32'h0301);
    chk("t5_w1_data", wr_log[1].data, 32'h00171615);
    chk("t5_w1_be", 32'(wr_log[1].be), 32'h7);
    chk("t5_ww", 32'(words_written), 32'd2);

    for (int i = 0; i < 8; i++) stream[i] = 8'(8'h50 + i);
    do_start(16'h0020, 8);
    feed(3, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) stream[i] = 8'(8'h60 + i);
    run_transfer(16'h0040, 5, 1'b0, 1'b0);
    chk("t6_nwrites", 32'(wr_log.size()), 32'd2);
    chk("t6_w0_data", wr_log[0].data, 32'h63626160);
    chk("t6_w1_data", wr_log[1].data, 32'h00000064);
    chk("t6_w1_be", 32'(wr_log[1].be), 32'h1);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
